// File: rtl/spi_master.sv
// spi_master: frames a 10-bit command word onto MOSI under SS_n and, for
// read-data commands, captures an RX_BITS reply from MISO after a turnaround.
module spi_master #(
    parameter int TURN_CYCLES = 2,
    parameter int RX_BITS     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [9:0]         tx_word,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [RX_BITS-1:0] rd_data,
    output logic               rd_valid,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);
    typedef enum logic [2:0] {S_IDLE, S_CLASS, S_SHIFT, S_TURN, S_RECV, S_END} state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] RX_LAST   = 4'(RX_BITS - 1);

    state_t             state_q, state_d;
    logic [9:0]         word_q, word_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [RX_BITS-1:0] rx_q, rx_d;
    logic [RX_BITS-1:0] rd_data_q, rd_data_d;
    logic               ss_q, ss_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d, rv_q, rv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            cnt_q     <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rv_q      <= rv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rx_d    = rx_q;
        unique case (state_q)
            S_IDLE, S_END: begin
                state_d = start ? S_CLASS : S_IDLE;
                word_d  = start ? tx_word : word_q;
            end
            S_CLASS: state_d = S_SHIFT;
            S_SHIFT: state_d = (cnt_q != 4'd9) ? S_SHIFT : (word_q[9:8] == 2'b11) ? S_TURN : S_END;
            S_TURN:  state_d = (cnt_q == TURN_LAST) ? S_RECV : S_TURN;
            S_RECV: begin
                rx_d    = {rx_q[RX_BITS-2:0], MISO};
                state_d = (cnt_q == RX_LAST) ? S_END : S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && !(state_q inside {S_IDLE, S_END}))
            state_d = S_IDLE;
        cnt_d = (state_d != state_q) ? 4'd0 : (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_d    = state_d inside {S_CLASS, S_SHIFT, S_TURN, S_RECV};
        ss_d      = !busy_d;
        mosi_d    = (state_d == S_CLASS) ? word_d[9] :
                    (state_d == S_SHIFT) ? word_d[4'd9 - cnt_d] : 1'b0;
        done_d    = state_d == S_END;
        rv_d      = done_d && word_d[9:8] == 2'b11;
        rd_data_d = (state_q == S_RECV && state_d == S_END) ? rx_d : rd_data_q;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rv_q;
    assign SS_n     = ss_q;
    assign MOSI     = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: drives cycle-indexed stimulus tables into spi_master and
// compares per-cycle traces against frame timing derived from word class.
module tb_spi_master;
    localparam int TURN = 2;
    localparam int RX   = 8;
    localparam int N    = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    tx_word = '0;
    logic          abort = 1'b0;
    logic          busy, done, rd_valid, SS_n, MOSI;
    logic          MISO = 1'b0;
    logic [RX-1:0] rd_data;

    spi_master #(.TURN_CYCLES(TURN), .RX_BITS(RX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_word(tx_word), .abort(abort),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // trace/expected packing: {SS_n, MOSI, busy, done, rd_valid}
    logic [4:0]    tr [N];
    logic [4:0]    e  [N];
    logic [RX-1:0] tr_rd [N];
    logic          st_start [N];
    logic          st_abort [N];
    logic [9:0]    st_word  [N];
    logic [RX-1:0] reply;
    logic [RX-1:0] rd_model = '0;

    task automatic clear();
        for (int k = 0; k < N; k++) begin
            st_start[k] = 1'b0;
            st_abort[k] = 1'b0;
            st_word[k]  = 10'($urandom);
            e[k]        = 5'b10000;
        end
        reply = '0;
    endtask

    // Expected outline of one frame whose CLASS cycle is c0; cut truncates an aborted frame.
    task automatic add_frame(input logic [9:0] w, input int c0, input int cut);
        int len;
        logic bit_out;
        len = (w[9:8] == 2'b11) ? 11 + TURN + RX : 11;
        for (int rel = 1; rel <= len; rel++) begin
            bit_out = (rel == 1) ? w[9] : (rel <= 11) ? w[11 - rel] : 1'b0;
            if (cut < 0 || c0 + rel - 1 <= cut)
                e[c0 + rel - 1] = {1'b0, bit_out, 1'b1, 1'b0, 1'b0};
        end
        if (cut < 0)
            e[c0 + len] = {1'b1, 1'b0, 1'b0, 1'b1, w[9:8] == 2'b11};
    endtask

    // Cycle k carries table row k; slave replies MSB first in the sampled window, noise elsewhere.
    task automatic run(input int n);
        int j;
        for (int k = 0; k < n; k++) begin
            start   = st_start[k];
            tx_word = st_word[k];
            abort   = st_abort[k];
            j       = k - (12 + TURN);
            MISO    = (j >= 0 && j < RX) ? reply[RX - 1 - j] : 1'($urandom);
            @(posedge clk);
            #1;
            tr[k + 1]    = {SS_n, MOSI, busy, done, rd_valid};
            tr_rd[k + 1] = rd_data;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({SS_n, MOSI, busy, done, rd_valid} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 10000", {SS_n, MOSI, busy, done, rd_valid});
        end
        tests++;
        if (rd_data !== '0) begin
            fails++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({SS_n, MOSI, busy, done, rd_valid} !== 5'b10000) begin
            fails++;
            $display("FAIL idle_after_reset: got %b expected 10000", {SS_n, MOSI, busy, done, rd_valid});
        end
    endtask

    task automatic test_write();
        clear();
        st_start[0] = 1'b1;
        st_word[0]  = 10'h0A5;
        st_abort[14] = 1'b1;
        add_frame(10'h0A5, 1, -1);
        run(16);
        for (int k = 1; k <= 16; k++) begin
            tests++;
            if (tr[k] !== e[k]) begin
                fails++;
                $display("FAIL write_addr cycle %0d: got %b expected %b", k, tr[k], e[k]);
            end
        end
        tests++;
        if (tr_rd[13] !== rd_model) begin
            fails++;
            $display("FAIL write_rd_data: got %h expected %h", tr_rd[13], rd_model);
        end
    endtask

    task automatic test_read(input logic [9:0] w, input logic [RX-1:0] rp, input string name);
        clear();
        reply       = rp;
        st_start[0] = 1'b1;
        st_word[0]  = w;
        add_frame(w, 1, -1);
        run(25);
        for (int k = 1; k <= 25; k++) begin
            tests++;
            if (tr[k] !== e[k]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, k, tr[k], e[k]);
            end
        end
        tests++;
        if (tr_rd[21] !== rd_model) begin
            fails++;
            $display("FAIL %s rd_data_before_end: got %h expected %h", name, tr_rd[21], rd_model);
        end
        if (w[9:8] == 2'b11)
            rd_model = rp;
        tests++;
        if (tr_rd[12 + TURN + RX] !== rd_model) begin
            fails++;
            $display("FAIL %s rd_data_at_end: got %h expected %h", name, tr_rd[12 + TURN + RX], rd_model);
        end
    endtask

    task automatic test_random();
        logic [9:0] w;
        repeat (8) begin
            w = 10'($urandom);
            test_read(w, RX'($urandom), "random_frame");
        end
    endtask

    task automatic test_back_to_back();
        clear();
        for (int k = 0; k <= 12; k++) begin
            st_start[k] = 1'b1;
            st_word[k]  = (k == 0) ? 10'h100 : 10'h200;
        end
        st_abort[12] = 1'b1;
        add_frame(10'h100, 1, -1);
        add_frame(10'h200, 13, -1);
        run(26);
        for (int k = 1; k <= 26; k++) begin
            tests++;
            if (tr[k] !== e[k]) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", k, tr[k], e[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] w, w2;
        test_read(10'h3C0, 8'h5A, "read_before_abort");
        clear();
        w            = {2'b11, 8'($urandom)};
        w2           = {1'b0, 9'($urandom)};
        reply        = 8'($urandom);
        st_start[0]  = 1'b1;
        st_word[0]   = w;
        st_abort[15 + TURN] = 1'b1;
        st_start[16 + TURN] = 1'b1;
        st_abort[16 + TURN] = 1'b1;
        st_word[16 + TURN]  = w2;
        add_frame(w, 1, 15 + TURN);
        add_frame(w2, 17 + TURN, -1);
        run(34);
        for (int k = 1; k <= 34; k++) begin
            tests++;
            if (tr[k] !== e[k] || tr_rd[k] !== 8'h5A) begin
                fails++;
                $display("FAIL abort_recv cycle %0d: got %b rd %h expected %b rd 5a", k, tr[k], tr_rd[k], e[k]);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [9:0] w;
        clear();
        w           = {1'b0, 9'($urandom)};
        st_start[0] = 1'b1;
        st_word[0]  = w;
        st_start[8] = 1'b1;
        st_word[8]  = ~w;
        add_frame(w, 1, -1);
        run(16);
        for (int k = 1; k <= 16; k++) begin
            tests++;
            if (tr[k] !== e[k]) begin
                fails++;
                $display("FAIL start_while_busy cycle %0d: got %b expected %b", k, tr[k], e[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear();
        st_start[0] = 1'b1;
        st_word[0]  = 10'h3AB;
        add_frame(10'h3AB, 1, -1);
        run(6);
        for (int k = 1; k <= 6; k++) begin
            tests++;
            if (tr[k] !== e[k]) begin
                fails++;
                $display("FAIL pre_reset cycle %0d: got %b expected %b", k, tr[k], e[k]);
            end
        end
        rst_n = 1'b0;
        #1;
        rd_model = '0;
        tests++;
        if ({SS_n, MOSI, busy, done, rd_valid} !== 5'b10000 || rd_data !== '0) begin
            fails++;
            $display("FAIL async_reset: got %b rd %h expected 10000 rd 00", {SS_n, MOSI, busy, done, rd_valid}, rd_data);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear();
        run(24);
        for (int k = 1; k <= 24; k++) begin
            tests++;
            if (tr[k] !== 5'b10000 || tr_rd[k] !== '0) begin
                fails++;
                $display("FAIL post_reset cycle %0d: got %b rd %h expected 10000 rd 00", k, tr[k], tr_rd[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(10'h3FF, 8'hC3, "read_data");
        test_random();
        test_back_to_back();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1);
    end
endmodule
